// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader: FSM states,
// error codes and the default frame header word.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MAGIC,
    WAIT_LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } ldr_state_t;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'b00,
    ERR_MAGIC   = 2'b01,
    ERR_LEN     = 2'b10,
    ERR_CSUM    = 2'b11
  } ldr_err_t;

  localparam logic [31:0] DEFAULT_MAGIC = 32'hBA11_0001;

  // States in which received bytes are assembled into words.
  function automatic logic accepts_bytes(input ldr_state_t s);
    return (s == WAIT_MAGIC) || (s == WAIT_LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_word_asm.sv
// Little-endian byte-to-word assembler. The completed word and its strobe are
// combinational on the fourth byte so the consumer can act on it that same cycle.
module word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  byte_idx
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] low_q, low_d;

  // NOTE: every variable gets a default at the top of always_comb, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_d = idx_q;
    low_d = low_q;
    if (clr) begin
      idx_d = 2'd0;
      low_d = 24'd0;
    end else if (byte_valid) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    low_d[7:0]   = byte_in;
        2'd1:    low_d[15:8]  = byte_in;
        2'd2:    low_d[23:16] = byte_in;
        default: low_d        = low_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= 2'd0;
      low_q <= 24'd0;
    end else begin
      idx_q <= idx_d;
      low_q <= low_d;
    end
  end

  assign word       = {byte_in, low_q};
  assign word_valid = byte_valid && !clr && (idx_q == 2'd3);
  assign byte_idx   = idx_q;

endmodule

// File: rtl/prog_loader.sv
// Frame loader: MAGIC, length N, N payload words, checksum. Writes the payload
// into program memory while holding the CPU in reset, with an inter-byte timeout.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter logic [31:0] MAGIC          = DEFAULT_MAGIC,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              rx_done,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned    TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0]  MAX_LEN  = (ADDR_W + 1)'(MAX_WORDS);

  ldr_state_t        state_q, state_d;
  ldr_err_t          err_code_q, err_code_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       sum_q, sum_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic [31:0] word;
  logic        word_valid;
  logic [1:0]  byte_idx;
  logic        byte_valid;
  logic        timing;
  logic        len_ok;
  logic [ADDR_W:0] words_inc;

  // A coincident start discards the byte.
  assign byte_valid = rx_done && !start && accepts_bytes(state_q);

  word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .word       (word),
    .word_valid (word_valid),
    .byte_idx   (byte_idx)
  );

  // The frame is under way once any header byte has arrived.
  assign timing = (state_q == WAIT_LEN) || (state_q == DATA) || (state_q == CSUM) ||
                  ((state_q == WAIT_MAGIC) && (byte_idx != 2'd0));

  assign len_ok = (word[31:ADDR_W+1] == '0) && (word[ADDR_W:0] != '0) &&
                  (word[ADDR_W:0] <= MAX_LEN);

  assign words_inc = words_loaded_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    err_code_d     = err_code_q;
    len_d          = len_q;
    addr_d         = addr_q;
    sum_d          = sum_q;
    words_loaded_d = words_loaded_q;
    timer_d        = timer_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;

    if (start) begin
      state_d        = WAIT_MAGIC;
      err_code_d     = ERR_TIMEOUT;
      addr_d         = '0;
      sum_d          = '0;
      words_loaded_d = '0;
      timer_d        = '0;
    end else begin
      if (rx_done || !timing) timer_d = '0;
      else                    timer_d = timer_q + 1'b1;

      case (state_q)
        WAIT_MAGIC: if (word_valid) begin
          if (word == MAGIC) begin
            state_d = WAIT_LEN;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_MAGIC;
          end
        end
        WAIT_LEN: if (word_valid) begin
          if (len_ok) begin
            state_d = DATA;
            len_d   = word[ADDR_W:0];
            addr_d  = '0;
            sum_d   = '0;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_LEN;
          end
        end
        DATA: if (word_valid) begin
          mem_we_d       = 1'b1;
          mem_addr_d     = addr_q;
          mem_wdata_d    = word;
          sum_d          = sum_q + word;
          addr_d         = addr_q + 1'b1;
          words_loaded_d = words_inc;
          if (words_inc == len_q) state_d = CSUM;
        end
        CSUM: if (word_valid) begin
          if (word == sum_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CSUM;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase

      if (timing && !rx_done && (timer_q == TMR_LAST)) begin
        state_d    = ERR;
        err_code_d = ERR_TIMEOUT;
      end
    end

    load_done_d = (state_d == DONE);
    load_err_d  = (state_d == ERR);
    cpu_hold_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      err_code_q     <= ERR_TIMEOUT;
      len_q          <= '0;
      addr_q         <= '0;
      sum_q          <= '0;
      words_loaded_q <= '0;
      timer_q        <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
      cpu_hold_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      err_code_q     <= err_code_d;
      len_q          <= len_d;
      addr_q         <= addr_d;
      sum_q          <= sum_d;
      words_loaded_q <= words_loaded_d;
      timer_q        <= timer_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      load_done_q    <= load_done_d;
      load_err_q     <= load_err_d;
      cpu_hold_q     <= cpu_hold_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign err_code     = err_code_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus random frames
// checked against a frame-level model of expected writes and outcome.
module tb_prog_loader;

  localparam logic [31:0] MAGIC = 32'hBA11_0001;
  localparam int          MAXW  = 1024;
  localparam int          TO    = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        rx_done;
  logic        start;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;
  logic [10:0] words_loaded;

  prog_loader #(
    .ADDR_W         (10),
    .MAX_WORDS      (MAXW),
    .MAGIC          (MAGIC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .rx_done      (rx_done),
    .start        (start),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor: every observed write and load_done pulse, sampled on the falling edge.
  logic [41:0] wr_q[$];
  int          done_total = 0;
  logic [31:0] pl_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we)    wr_q.push_back({mem_addr, mem_wdata});
      if (load_done) done_total++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the falling edge right after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_in = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) idle(gap);
      send_byte(w[8*k +: 8]);
    end
  endtask

  // Drives one framed load (payload from pl_q) and compares against the model.
  task automatic run_frame(input logic [31:0] magic, input logic [31:0] len,
                           input logic [31:0] csum, input int gap, input string tag);
    logic [31:0] s;
    logic        exp_err;
    logic [1:0]  exp_code;
    int          nexp;
    int          wb;
    int          db;
    logic [9:0]  a;

    s = 32'd0;
    foreach (pl_q[i]) s = s + pl_q[i];
    exp_err  = 1'b0;
    exp_code = 2'b00;
    nexp     = 0;
    if (magic != MAGIC) begin
      exp_err = 1'b1; exp_code = 2'b01;
    end else if (len == 32'd0 || len > MAXW) begin
      exp_err = 1'b1; exp_code = 2'b10;
    end else begin
      nexp = int'(len);
      if (csum != s) begin
        exp_err = 1'b1; exp_code = 2'b11;
      end
    end

    pulse_start();
    check({tag, "_err_cleared"}, load_err, 0);
    wb = wr_q.size();
    db = done_total;

    send_word(magic, gap);
    if (magic == MAGIC) begin
      idle(gap);
      send_word(len, gap);
      if (len != 32'd0 && len <= MAXW) begin
        foreach (pl_q[i]) begin
          idle(gap);
          send_word(pl_q[i], gap);
        end
        idle(gap);
        send_word(csum, gap);
      end
    end
    idle(4);

    check({tag, "_load_err"}, load_err, exp_err);
    if (exp_err) check({tag, "_err_code"}, err_code, exp_code);
    check({tag, "_done_pulses"}, done_total - db, exp_err ? 0 : 1);
    check({tag, "_write_count"}, wr_q.size() - wb, nexp);
    for (int i = 0; i < nexp && (wb + i) < wr_q.size(); i++) begin
      a = i[9:0];
      check({tag, "_write"}, wr_q[wb + i], {a, pl_q[i]});
    end
    check({tag, "_words_loaded"}, words_loaded, nexp);
    check({tag, "_cpu_hold"}, cpu_hold, exp_err);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] s;
    logic [31:0] magic;
    logic [31:0] csum;
    int          n;
    int          gap;

    rst     = 1'b1;
    start   = 1'b0;
    rx_done = 1'b0;
    byte_in = 8'h00;
    #12;
    check("reset_outputs", {mem_we, cpu_hold, load_done, load_err, err_code, words_loaded}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    check("idle_cpu_hold", cpu_hold, 0);

    // Happy path with latency checks.
    pulse_start();
    check("armed_cpu_hold", cpu_hold, 1);
    send_word(MAGIC, 10); idle(10);
    send_word(32'd3, 10);
    for (int i = 0; i < 3; i++) begin
      v = 32'h11 * (i + 1);
      idle(10);
      send_word(v, 10);
      check("happy_we", mem_we, 1);
      check("happy_addr", mem_addr, i);
      check("happy_data", mem_wdata, v);
      @(negedge clk);
      check("happy_we_one_cycle", mem_we, 0);
    end
    check("happy_words_loaded", words_loaded, 3);
    idle(10);
    send_word(32'h66, 10);
    check("happy_done", load_done, 1);
    check("happy_hold_at_done", cpu_hold, 1);
    @(negedge clk);
    check("happy_done_once", load_done, 0);
    check("happy_hold_released", cpu_hold, 0);

    // Bad magic, then recovery with a valid one-word frame.
    pl_q.delete();
    run_frame(32'hDEAD_BEEF, 32'd0, 32'd0, 3, "bad_magic");
    pulse_start();
    check("bad_magic_err_cleared", load_err, 0);
    pl_q.delete(); pl_q.push_back(32'h1234_5678);
    run_frame(MAGIC, 32'd1, 32'h1234_5678, 2, "one_word");

    // Bad lengths, including upper bits set over an otherwise legal value.
    pl_q.delete();
    run_frame(MAGIC, 32'd0, 32'd0, 1, "len_zero");
    run_frame(MAGIC, 32'd1025, 32'd0, 1, "len_1025");
    run_frame(MAGIC, 32'h0001_0001, 32'd0, 1, "len_upper");

    // Checksum mismatch, then the wrapped checksum.
    pl_q.delete(); pl_q.push_back(32'hFFFF_FFFF); pl_q.push_back(32'h0000_0002);
    run_frame(MAGIC, 32'd2, 32'h0000_0000, 2, "csum_bad");
    run_frame(MAGIC, 32'd2, 32'h0000_0001, 2, "csum_wrap");

    // Largest legal frame.
    pl_q.delete();
    s = 32'd0;
    for (int i = 0; i < MAXW; i++) begin
      v = $urandom;
      pl_q.push_back(v);
      s = s + v;
    end
    run_frame(MAGIC, MAXW, s, 0, "len_max");

    // Timeout exactly TO cycles after the last byte.
    pulse_start();
    send_byte(8'h01);
    idle(3);
    send_byte(8'h00);
    idle(TO - 1);
    check("timeout_not_early", load_err, 0);
    @(negedge clk);
    check("timeout_err", load_err, 1);
    check("timeout_code", err_code, 2'b00);
    check("timeout_hold", cpu_hold, 1);

    // Armed with no bytes waits indefinitely.
    pulse_start();
    idle(1000);
    check("idle_wait_no_err", load_err, 0);
    check("idle_wait_hold", cpu_hold, 1);

    // Abort mid-DATA with start and rx_done together.
    pulse_start();
    send_word(MAGIC, 2); idle(2);
    send_word(32'd4, 2); idle(2);
    send_word(32'hAAAA_0001, 2); idle(2);
    send_word(32'hAAAA_0002, 2); idle(2);
    check("abort_words_before", words_loaded, 2);
    send_byte(8'h55);
    @(negedge clk);
    start   = 1'b1;
    rx_done = 1'b1;
    byte_in = 8'hEE;
    @(negedge clk);
    start   = 1'b0;
    rx_done = 1'b0;
    check("abort_words_cleared", words_loaded, 0);
    check("abort_no_err", load_err, 0);
    send_word(MAGIC, 1); idle(1);
    send_word(32'd1, 1); idle(1);
    send_word(32'hC0DE_0042, 1);
    check("abort_fresh_we", mem_we, 1);
    check("abort_fresh_addr", mem_addr, 0);
    idle(1);
    send_word(32'hC0DE_0042, 1);
    check("abort_fresh_done", load_done, 1);

    // Random frames against the model.
    for (int r = 0; r < 8; r++) begin
      n   = $urandom_range(1, 6);
      gap = $urandom_range(0, 4);
      pl_q.delete();
      s = 32'd0;
      for (int i = 0; i < n; i++) begin
        v = $urandom;
        pl_q.push_back(v);
        s = s + v;
      end
      magic = MAGIC;
      csum  = s;
      case ($urandom_range(0, 3))
        0:       csum  = s ^ (32'd1 << $urandom_range(0, 31));
        1:       magic = MAGIC ^ (32'd1 << $urandom_range(0, 31));
        default: csum  = s;
      endcase
      run_frame(magic, n, csum, gap, "random");
    end

    // Reset mid-frame drops outputs immediately.
    pulse_start();
    send_word(MAGIC, 1); idle(1);
    send_word(32'd3, 1); idle(1);
    send_word(32'h0000_0077, 1);
    check("rst_pre_we", mem_we, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {mem_we, cpu_hold, load_done, load_err, words_loaded}, 0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h01);
    idle(2);
    check("rst_idle_hold", cpu_hold, 0);
    pl_q.delete(); pl_q.push_back(32'h0BAD_F00D);
    run_frame(MAGIC, 32'd1, 32'h0BAD_F00D, 1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
